// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep sequencer and its sibling exercises.
// Reference maps: bit i is the expected output for input vector i, where a is the MSB.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } tt_state_e;

   localparam logic [15:0] Q0101_MAP = 16'h6996;  // odd parity of a,b,c,d
   localparam logic [15:0] Q0102_MAP = 16'hE880;  // at least three inputs high
   localparam logic [15:0] Q0103_MAP = 16'hAC3C;  // ~b&c | ~a&b&~c | a&b&d

endpackage

// File: rtl/truth_table_sweeper.sv
// Drives every input combination to a combinational block, samples its output after a
// settle interval, and compares the resulting minterm map with a reference map.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int unsigned          N_IN          = 4,
   parameter int unsigned          SETTLE_CYCLES = 1,
   parameter logic [2**N_IN-1:0]   EXPECTED      = Q0103_MAP
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 dut_s,
   output logic [N_IN-1:0]      vec_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2**N_IN-1:0]   captured,
   output logic [N_IN:0]        mismatch_count,
   output logic [N_IN-1:0]      first_fail_idx,
   output logic                 fail_seen
);

   localparam int unsigned    N_VEC       = 2**N_IN;
   localparam int unsigned    SW          = $clog2(SETTLE_CYCLES + 1);
   localparam logic [N_IN-1:0] LAST_VEC   = '1;
   localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [N_IN:0]  MM_MAX      = (N_IN+1)'(N_VEC);

   tt_state_e            state, state_nxt;
   logic [SW-1:0]        settle_cnt, settle_cnt_nxt;
   logic [N_IN-1:0]      vec_nxt;
   logic                 busy_nxt, done_nxt, pass_nxt, fail_seen_nxt;
   logic [N_VEC-1:0]     captured_nxt;
   logic [N_IN:0]        mismatch_nxt;
   logic [N_IN-1:0]      first_fail_nxt;

   // done is still high during the first IDLE cycle; a start there must not be accepted
   logic accept;
   assign accept = start && !done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         vec_out        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         captured       <= '0;
         mismatch_count <= '0;
         first_fail_idx <= '0;
         fail_seen      <= 1'b0;
      end else begin
         state          <= state_nxt;
         settle_cnt     <= settle_cnt_nxt;
         vec_out        <= vec_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         pass           <= pass_nxt;
         captured       <= captured_nxt;
         mismatch_count <= mismatch_nxt;
         first_fail_idx <= first_fail_nxt;
         fail_seen      <= fail_seen_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (vec_out == LAST_VEC) ? DONE : SETTLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      settle_cnt_nxt = settle_cnt;
      vec_nxt        = vec_out;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      pass_nxt       = pass;
      captured_nxt   = captured;
      mismatch_nxt   = mismatch_count;
      first_fail_nxt = first_fail_idx;
      fail_seen_nxt  = fail_seen;
      case (state)
         IDLE: begin
            if (accept) begin
               settle_cnt_nxt = '0;
               vec_nxt        = '0;
               busy_nxt       = 1'b1;
               pass_nxt       = 1'b0;
               captured_nxt   = '0;
               mismatch_nxt   = '0;
               first_fail_nxt = '0;
               fail_seen_nxt  = 1'b0;
            end
         end
         SETTLE: begin
            settle_cnt_nxt = settle_cnt + 1'b1;
         end
         SAMPLE: begin
            captured_nxt[vec_out] = dut_s;
            if (dut_s != EXPECTED[vec_out]) begin
               if (mismatch_count != MM_MAX) mismatch_nxt = mismatch_count + 1'b1;
               if (!fail_seen) begin
                  first_fail_nxt = vec_out;
                  fail_seen_nxt  = 1'b1;
               end
            end
            if (vec_out != LAST_VEC) begin
               vec_nxt        = vec_out + 1'b1;
               settle_cnt_nxt = '0;
            end
         end
         DONE: begin
            done_nxt = 1'b1;
            pass_nxt = (mismatch_count == '0);
            busy_nxt = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a behavioural exercise block feeds dut_s and the
// sweep results are compared with hand-derived minterm maps.
module tb_truth_table_sweeper;
   import tt_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start1, start3;
   int   mode;
   int   tests = 0;
   int   fails = 0;

   logic        s1, busy1, done1, pass1, fs1;
   logic [3:0]  vec1, ffi1;
   logic [15:0] cap1;
   logic [4:0]  mm1;
   logic        s3, busy3, done3, pass3, fs3;
   logic [3:0]  vec3, ffi3;
   logic [15:0] cap3;
   logic [4:0]  mm3;

   // mode 0: reference block, 1: output stuck low, 2: a&b&d term missing
   function automatic logic model(input int m, input logic [3:0] v);
      logic a, b, c, d;
      {a, b, c, d} = v;
      case (m)
         0:       return (~b & c) | (~a & b & ~c) | (a & b & d);
         1:       return 1'b0;
         default: return (~b & c) | (~a & b & ~c);
      endcase
   endfunction

   assign s1 = model(mode, vec1);
   assign s3 = model(mode, vec3);

   truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1), .EXPECTED(Q0103_MAP)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dut_s(s1), .vec_out(vec1),
      .busy(busy1), .done(done1), .pass(pass1), .captured(cap1),
      .mismatch_count(mm1), .first_fail_idx(ffi1), .fail_seen(fs1)
   );

   truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(3), .EXPECTED(Q0103_MAP)) u_s3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .dut_s(s3), .vec_out(vec3),
      .busy(busy3), .done(done3), .pass(pass3), .captured(cap3),
      .mismatch_count(mm3), .first_fail_idx(ffi3), .fail_seen(fs3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset1(input string tag);
      check({tag, " vec"},   32'(vec1),  32'h0);
      check({tag, " busy"},  32'(busy1), 32'h0);
      check({tag, " done"},  32'(done1), 32'h0);
      check({tag, " pass"},  32'(pass1), 32'h0);
      check({tag, " cap"},   32'(cap1),  32'h0);
      check({tag, " mm"},    32'(mm1),   32'h0);
      check({tag, " ffi"},   32'(ffi1),  32'h0);
      check({tag, " fs"},    32'(fs1),   32'h0);
   endtask

   // Pulses start on instance sel (0: SETTLE_CYCLES=1, 1: =3) and follows the sweep edge by
   // edge. bad counts vector steps that are not +1 or not held SETTLE_CYCLES+1 clocks.
   task automatic sweep(input int sel, input int unsigned x1, input int unsigned x2,
                        input bit start_on_done, output int unsigned done_edge,
                        output int unsigned bad, output int unsigned pulses);
      logic [3:0]  prev, cur;
      int unsigned hold, hold_exp;
      bit          got, dn;
      hold_exp = (sel == 0) ? 2 : 4;
      if (sel == 0) start1 = 1'b1; else start3 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; start3 = 1'b0;
      prev = 4'd0; hold = 1; got = 1'b0; done_edge = 0; bad = 0; pulses = 0;
      for (int unsigned n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         start1 = 1'b0; start3 = 1'b0;
         cur = (sel == 0) ? vec1 : vec3;
         dn  = (sel == 0) ? done1 : done3;
         if (!got) begin
            if (cur != prev) begin
               if (cur != 4'(prev + 4'd1) || hold != hold_exp) bad++;
               hold = 1;
               prev = cur;
            end else begin
               hold++;
            end
         end
         if (dn) begin
            pulses++;
            if (!got) begin
               got = 1'b1;
               done_edge = n;
            end
         end
         if (n == x1 || n == x2 || (dn && start_on_done)) begin
            if (sel == 0) start1 = 1'b1; else start3 = 1'b1;
         end
         if (got && n >= done_edge + 6) break;
      end
   endtask

   int unsigned de, bad, pulses;

   initial begin
      rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; mode = 0;
      #12;
      check_reset1("reset");
      check("reset busy3", 32'(busy3), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // reference block
      sweep(0, 0, 0, 1'b0, de, bad, pulses);
      check("ref done_edge", de, 33);
      check("ref steps",     bad, 0);
      check("ref pulses",    pulses, 1);
      check("ref cap",       32'(cap1), 32'hAC3C);
      check("ref pass",      32'(pass1), 32'h1);
      check("ref mm",        32'(mm1), 32'h0);
      check("ref fs",        32'(fs1), 32'h0);
      check("ref vec_last",  32'(vec1), 32'hF);
      check("ref busy",      32'(busy1), 32'h0);

      // output stuck low: misses all 8 ones, lowest at vector 2
      mode = 1;
      sweep(0, 0, 0, 1'b0, de, bad, pulses);
      check("zero cap",  32'(cap1), 32'h0000);
      check("zero mm",   32'(mm1), 32'd8);
      check("zero ffi",  32'(ffi1), 32'd2);
      check("zero fs",   32'(fs1), 32'h1);
      check("zero pass", 32'(pass1), 32'h0);

      // missing a&b&d: vectors 13 and 15 read 0
      mode = 2;
      sweep(0, 0, 0, 1'b0, de, bad, pulses);
      check("drop cap",  32'(cap1), 32'h0C3C);
      check("drop mm",   32'(mm1), 32'd2);
      check("drop ffi",  32'(ffi1), 32'd13);
      check("drop fs",   32'(fs1), 32'h1);
      check("drop pass", 32'(pass1), 32'h0);

      // starts mid-sweep and during the done cycle are all ignored
      mode = 0;
      sweep(0, 5, 20, 1'b1, de, bad, pulses);
      check("restart done_edge", de, 33);
      check("restart steps",     bad, 0);
      check("restart pulses",    pulses, 1);
      check("restart busy",      32'(busy1), 32'h0);
      check("restart pass",      32'(pass1), 32'h1);
      check("restart cap",       32'(cap1), 32'hAC3C);

      // asynchronous reset at vector 7 with failures already recorded
      mode = 1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      begin
         int unsigned k;
         k = 0;
         while (vec1 != 4'd7 && k < 100) begin
            @(posedge clk); #1;
            k++;
         end
         check("abort reach7", 32'(vec1), 32'h7);
      end
      check("abort fs_before", 32'(fs1), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check_reset1("abort");
      @(negedge clk); rst_n = 1'b1;
      mode = 0;
      @(negedge clk);
      sweep(0, 0, 0, 1'b0, de, bad, pulses);
      check("post_abort done_edge", de, 33);
      check("post_abort steps",     bad, 0);
      check("post_abort cap",       32'(cap1), 32'hAC3C);
      check("post_abort pass",      32'(pass1), 32'h1);

      // longer settle interval: 4 clocks per vector
      sweep(1, 0, 0, 1'b0, de, bad, pulses);
      check("s3 done_edge", de, 65);
      check("s3 steps",     bad, 0);
      check("s3 pulses",    pulses, 1);
      check("s3 cap",       32'(cap3), 32'hAC3C);
      check("s3 pass",      32'(pass3), 32'h1);
      check("s3 mm",        32'(mm3), 32'h0);
      check("s3 fs",        32'(fs3), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
